// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer and the 8x8 LCD controller:
// command codes, frame geometry and the sequencer state encoding.
package lcd_pkg;

   typedef enum logic [2:0] {
      CMD_REFLASH = 3'd0,
      CMD_LOAD    = 3'd1,
      CMD_ZOOMIN  = 3'd2,
      CMD_ZOOMOUT = 3'd3,
      CMD_SHIFT_R = 3'd4,
      CMD_SHIFT_L = 3'd5,
      CMD_SHIFT_U = 3'd6,
      CMD_SHIFT_D = 3'd7
   } lcd_cmd_e;

   localparam int NUM_PIX = 64;
   localparam int PIX_W   = 6;
   localparam int CNT_W   = 7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREFETCH  = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_STREAM    = 3'd3,
      ST_WAIT_BUSY = 3'd4
   } seq_state_e;

   function automatic logic is_load(input logic [2:0] code);
      return code == CMD_LOAD;
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO with count-based full/empty and show-ahead read data.
// Only instantiated by lcd_cmd_seq when LCD_CMD_FIFO_EN is defined.
module lcd_cmd_fifo #(
   parameter int W   = 5,
   parameter int DEP = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEP);

   logic [W-1:0]  mem [DEP];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEP));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-LCD-controller command sequencer; streams 64 ROM pixels for LOAD.
// Define LCD_CMD_FIFO_EN to place a FIFO_DEP-entry command FIFO in front of the FSM.
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int FRM_W    = 2,
   parameter int FIFO_DEP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       host_cmd,
   input  logic [FRM_W-1:0] host_frame,
   input  logic             host_valid,
   output logic             host_ready,
   output logic             img_rd,
   output logic [FRM_W+5:0] img_addr,
   input  logic [7:0]       img_data,
   input  logic             busy,
   output logic [2:0]       cmd,
   output logic             cmd_valid,
   output logic [7:0]       datain,
   output logic             seq_idle,
   output logic [2:0]       dbg_state
);

   seq_state_e       state;
   logic [2:0]       cmd_q;
   logic [FRM_W-1:0] frame_q;
   logic [CNT_W-1:0] pix_cnt;
   logic [PIX_W-1:0] next_pix;
   logic             guard;
   logic             data_vld;

   logic             take;
   logic [2:0]       take_cmd;
   logic [FRM_W-1:0] take_frame;
   logic             pend_empty;

   // Host handshake: a command transfers on a rising clk edge where host_valid && host_ready;
   // host_valid may drop at any time before that edge with no effect, and host_ready never
   // depends on host_valid.
`ifdef LCD_CMD_FIFO_EN
   localparam int ENT_W = 3 + FRM_W;

   logic             fifo_full;
   logic             fifo_empty;
   logic [ENT_W-1:0] fifo_head;

   assign host_ready = reset && !fifo_full;
   assign take       = (state == ST_IDLE) && !busy && !fifo_empty;
   assign take_cmd   = fifo_head[ENT_W-1 -: 3];
   assign take_frame = fifo_head[FRM_W-1:0];
   assign pend_empty = fifo_empty;

   lcd_cmd_fifo #(
      .W   (ENT_W),
      .DEP (FIFO_DEP)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (host_valid && host_ready),
      .push_data ({host_cmd, host_frame}),
      .pop       (take),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   assign host_ready = reset && (state == ST_IDLE) && !busy;
   assign take       = host_valid && host_ready;
   assign take_cmd   = host_cmd;
   assign take_frame = host_frame;
   assign pend_empty = 1'b1;
`endif

   assign seq_idle  = reset && (state == ST_IDLE) && pend_empty;
   assign dbg_state = state;
   assign next_pix  = pix_cnt[PIX_W-1:0] + PIX_W'(1);

   // pix_cnt is the pixel index currently on img_addr; it runs two past the last pixel so the
   // FSM stays in STREAM until pixel 63 has been presented on datain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cmd_q     <= '0;
         frame_q   <= '0;
         pix_cnt   <= '0;
         guard     <= 1'b0;
         data_vld  <= 1'b0;
         img_rd    <= 1'b0;
         img_addr  <= '0;
         cmd       <= '0;
         cmd_valid <= 1'b0;
         datain    <= '0;
      end else begin
         cmd_valid <= 1'b0;
         img_rd    <= 1'b0;
         data_vld  <= img_rd;
         if (data_vld) datain <= img_data;

         case (state)
            ST_IDLE: begin
               if (take) begin
                  cmd_q   <= take_cmd;
                  frame_q <= take_frame;
                  pix_cnt <= '0;
                  if (is_load(take_cmd)) begin
                     state    <= ST_PREFETCH;
                     img_rd   <= 1'b1;
                     img_addr <= {take_frame, PIX_W'(0)};
                  end else begin
                     state     <= ST_ISSUE;
                     cmd_valid <= 1'b1;
                     cmd       <= take_cmd;
                  end
               end
            end

            ST_PREFETCH: begin
               state     <= ST_ISSUE;
               cmd_valid <= 1'b1;
               cmd       <= cmd_q;
               img_rd    <= 1'b1;
               img_addr  <= {frame_q, next_pix};
               pix_cnt   <= pix_cnt + CNT_W'(1);
            end

            ST_ISSUE: begin
               if (is_load(cmd_q)) begin
                  state    <= ST_STREAM;
                  img_rd   <= 1'b1;
                  img_addr <= {frame_q, next_pix};
                  pix_cnt  <= pix_cnt + CNT_W'(1);
               end else begin
                  state <= ST_WAIT_BUSY;
                  guard <= 1'b1;
               end
            end

            ST_STREAM: begin
               pix_cnt <= pix_cnt + CNT_W'(1);
               if (pix_cnt < CNT_W'(NUM_PIX - 1)) begin
                  img_rd   <= 1'b1;
                  img_addr <= {frame_q, next_pix};
               end
               if (pix_cnt == CNT_W'(NUM_PIX + 1)) begin
                  state <= ST_WAIT_BUSY;
                  guard <= 1'b1;
               end
            end

            // The guard cycle gives the controller one clock to raise busy for the command
            // just issued before the FSM is allowed to look at it.
            ST_WAIT_BUSY: begin
               if (guard) begin
                  guard <= 1'b0;
               end else if (!busy) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: vector table, directed corner cases and random traffic
// checked against a cycle-level reference of the handshake/issue/stream rules.
module tb_lcd_cmd_seq;
   import lcd_pkg::*;

   localparam int FRM_W = 2;
   localparam int AW    = FRM_W + 6;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       host_cmd = '0;
   logic [FRM_W-1:0] host_frame = '0;
   logic             host_valid = 1'b0;
   logic             host_ready;
   logic             img_rd;
   logic [AW-1:0]    img_addr;
   logic [7:0]       img_data = '0;
   logic             busy = 1'b0;
   logic [2:0]       cmd;
   logic             cmd_valid;
   logic [7:0]       datain;
   logic             seq_idle;
   logic [2:0]       dbg_state;

   lcd_cmd_seq #(.FRM_W(FRM_W), .FIFO_DEP(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .host_cmd   (host_cmd),
      .host_frame (host_frame),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .img_rd     (img_rd),
      .img_addr   (img_addr),
      .img_data   (img_data),
      .busy       (busy),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .datain     (datain),
      .seq_idle   (seq_idle),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset / environment models ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rom [256];
   always @(posedge clk) img_data <= img_rd ? rom[img_addr] : 8'($urandom);

   // Controller model: goes busy the cycle after a command strobe.
   bit force_busy = 0, rnd_busy_en = 0, ctl_quiet = 0;
   int ctl_cnt = 0;
   always @(posedge clk) begin
      #2;
      busy = force_busy || (ctl_cnt > 0) || (rnd_busy_en && $urandom_range(0, 3) == 0);
      if (ctl_cnt > 0) ctl_cnt--;
      if (reset && cmd_valid && !ctl_quiet)
         ctl_cnt = (cmd == CMD_LOAD) ? 70 : $urandom_range(1, 4);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", 0);
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int checks = 0, errors = 0;
   logic [2:0]       exp_q[$];
   logic [FRM_W-1:0] frame_q[$];
   logic [2:0]       got_q[$];
   int               cv_cyc_q[$];
   int               exp_rd[int];
   bit               exp_cv[int];
   bit               occ = 0;
   int               wb_start = 0;
   bit               cap_on = 0;
   int               cap_start = 0;
   int               cap_frame = 0;
   logic [7:0]       ctl_img [64];

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic monitor();
      bit exp_ready;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("reset_outputs", int'({host_ready, img_rd, img_addr, cmd, cmd_valid, datain, seq_idle}), 0);
            occ = 0; cap_on = 0;
            exp_rd.delete(); exp_cv.delete(); exp_q.delete(); frame_q.delete();
            continue;
         end
         exp_ready = !occ && !busy;
`ifndef LCD_CMD_FIFO_EN
         check("host_ready", host_ready, exp_ready);
         check("seq_idle", seq_idle, !occ);
         check("img_rd", img_rd, exp_rd.exists(cyc));
         if (exp_rd.exists(cyc) && img_rd) check("img_addr", img_addr, exp_rd[cyc]);
         check("cmd_valid", cmd_valid, exp_cv.exists(cyc));
         exp_rd.delete(cyc);
         exp_cv.delete(cyc);
`endif
         if (cmd_valid) begin
            got_q.push_back(cmd);
            cv_cyc_q.push_back(cyc);
            check("cmd_order", cmd, (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 8);
            if (cmd == CMD_LOAD) begin
               cap_on = 1;
               cap_start = cyc + 1;
               cap_frame = (frame_q.size() > 0) ? int'(frame_q.pop_front()) : 0;
            end
         end
         if (cap_on && cyc >= cap_start && cyc < cap_start + 64) ctl_img[cyc - cap_start] = datain;
         if (cap_on && cyc == cap_start + 63) begin
            int bad = 0;
            for (int k = 0; k < 64; k++) if (ctl_img[k] != rom[cap_frame * 64 + k]) bad++;
            check("ctl_store_bad_pixels", bad, 0);
         end
         if (cap_on && cyc == cap_start + 64) begin
            check("datain_hold", datain, rom[cap_frame * 64 + 63]);
            cap_on = 0;
         end
`ifndef LCD_CMD_FIFO_EN
         if (host_valid && exp_ready) begin
            occ = 1;
            exp_q.push_back(host_cmd);
            if (host_cmd == CMD_LOAD) begin
               for (int k = 0; k < 64; k++) exp_rd[cyc + 1 + k] = int'(host_frame) * 64 + k;
               exp_cv[cyc + 2] = 1;
               wb_start = cyc + 67;
               frame_q.push_back(host_frame);
            end else begin
               exp_cv[cyc + 1] = 1;
               wb_start = cyc + 2;
            end
         end else if (occ && cyc > wb_start && !busy) begin
            occ = 0;
         end
`else
         if (host_valid && host_ready) begin
            exp_q.push_back(host_cmd);
            if (host_cmd == CMD_LOAD) frame_q.push_back(host_frame);
         end
`endif
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] c, input logic [FRM_W-1:0] f, input int max_wait,
                       input bit must, output bit acc);
      host_cmd = c;
      host_frame = f;
      host_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < max_wait; i++) begin
         @(negedge clk);
         if (host_ready) begin
            acc = 1;
            break;
         end
      end
      sync();
      host_valid = 1'b0;
      if (must) check("accept_timeout", acc, 1);
   endtask

   task automatic wait_idle(input int max_wait);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!seq_idle && i < max_wait);
      check("idle_timeout", seq_idle, 1);
      sync();
   endtask

   typedef struct {
      logic [2:0]       hcmd;
      logic [FRM_W-1:0] hframe;
      logic [2:0]       exp_cmd;
      int               exp_lat;
      bit               exp_rd0;
      int               exp_addr0;
   } vec_t;

   task automatic run_vec(input vec_t v);
      bit acc;
      int lat;
      send(v.hcmd, v.hframe, 300, 1, acc);
      if (!acc) return;
      @(negedge clk);
      check("vec_rd0", img_rd, v.exp_rd0);
      if (v.exp_rd0) check("vec_addr0", img_addr, v.exp_addr0);
      lat = 1;
      while (!cmd_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check("vec_latency", lat, v.exp_lat);
      check("vec_cmd", cmd, v.exp_cmd);
      wait_idle(300);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t vecs[10];
      bit   acc;
      int   n, base;

      vecs = '{
         '{3'd1, 2'd2, 3'd1, 2, 1'b1, 128},
         '{3'd2, 2'd0, 3'd2, 1, 1'b0, 0},
         '{3'd3, 2'd1, 3'd3, 1, 1'b0, 0},
         '{3'd4, 2'd3, 3'd4, 1, 1'b0, 0},
         '{3'd5, 2'd0, 3'd5, 1, 1'b0, 0},
         '{3'd6, 2'd2, 3'd6, 1, 1'b0, 0},
         '{3'd7, 2'd1, 3'd7, 1, 1'b0, 0},
         '{3'd0, 2'd3, 3'd0, 1, 1'b0, 0},
         '{3'd1, 2'd3, 3'd1, 2, 1'b1, 192},
         '{3'd1, 2'd0, 3'd1, 2, 1'b1, 0}
      };
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

      #1 reset = 1'b0;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("post_reset_seq_idle", seq_idle, 1);
      check("post_reset_host_ready", host_ready, 1);
      sync();

`ifndef LCD_CMD_FIFO_EN
      // Vector table: each command's issue latency, code and first ROM read.
      foreach (vecs[i]) run_vec(vecs[i]);

      // busy holds off a pending command; single issue once busy falls.
      force_busy = 1;
      sync();
      host_cmd = 3'd2; host_frame = '0; host_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("busy_blocks_ready", host_ready, 0);
      end
      sync();
      force_busy = 0;
      run_vec('{3'd2, 2'd0, 3'd2, 1, 1'b0, 0});

      // Back-to-back 4,4,6 with host_valid held.
      base = got_q.size();
      send(3'd4, 2'd0, 50, 1, acc);
      send(3'd4, 2'd0, 50, 1, acc);
      send(3'd6, 2'd0, 50, 1, acc);
      wait_idle(100);
      check("b2b_count", got_q.size() - base, 3);
      if (got_q.size() - base == 3) begin
         check("b2b_cmd0", got_q[base], 4);
         check("b2b_cmd1", got_q[base + 1], 4);
         check("b2b_cmd2", got_q[base + 2], 6);
         check("b2b_gap01", (cv_cyc_q[base + 1] - cv_cyc_q[base]) > 1, 1);
         check("b2b_gap12", (cv_cyc_q[base + 2] - cv_cyc_q[base + 1]) > 1, 1);
      end

      // Reset in the middle of a LOAD stream, then a fresh LOAD from pixel 0.
      send(3'd1, 2'd1, 50, 1, acc);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(img_rd && img_addr[5:0] == 6'd30) && n < 100);
      check("reach_pixel30", img_addr, 64 + 30);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_fsm_idle", dbg_state, ST_IDLE);
      sync();
      reset = 1'b1;
      run_vec('{3'd1, 2'd1, 3'd1, 2, 1'b1, 64});

      // host_valid pulsed during the WAIT_BUSY guard cycle with busy low.
      ctl_quiet = 1;
      send(3'd3, 2'd0, 50, 1, acc);
      sync();
      host_cmd = 3'd5; host_valid = 1'b1;
      @(negedge clk);
      check("guard_ready", host_ready, 0);
      sync();
      host_valid = 1'b0;
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (cmd_valid) n++;
      end
      check("guard_no_issue", n, 0);
      ctl_quiet = 0;
      sync();
`else
      // FIFO: four pushes while busy, fifth refused, issued in order after busy drops.
      force_busy = 1;
      sync();
      base = got_q.size();
      send(3'd3, 2'd0, 5, 1, acc);
      send(3'd5, 2'd0, 5, 1, acc);
      send(3'd7, 2'd0, 5, 1, acc);
      send(3'd0, 2'd0, 5, 1, acc);
      host_cmd = 3'd4; host_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("fifo_full_refuse", host_ready, 0);
      end
      check("fifo_not_idle", seq_idle, 0);
      sync();
      host_valid = 1'b0;
      force_busy = 0;
      wait_idle(200);
      check("fifo_count", got_q.size() - base, 4);
      if (got_q.size() - base == 4) begin
         check("fifo_cmd0", got_q[base], 3);
         check("fifo_cmd1", got_q[base + 1], 5);
         check("fifo_cmd2", got_q[base + 2], 7);
         check("fifo_cmd3", got_q[base + 3], 0);
      end
`endif

      // Random traffic against the reference: random codes, frames, gaps, aborts and busy noise.
      rnd_busy_en = 1;
      for (int i = 0; i < 120; i++) begin
         logic [2:0] c;
         c = 3'($urandom_range(0, 7));
         if (c == CMD_LOAD && $urandom_range(0, 2) != 0) c = CMD_ZOOMIN;
         repeat ($urandom_range(0, 3)) sync();
         if ($urandom_range(0, 4) == 0)
            send(c, FRM_W'($urandom), $urandom_range(1, 3), 0, acc);
         else
            send(c, FRM_W'($urandom), 300, 1, acc);
      end
      rnd_busy_en = 0;
      wait_idle(300);
      check("all_issued", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
